// File: rtl/operand_seq_pkg.sv
// rtl/operand_seq_pkg.sv - shared state encoding and defaults for the operand sequencer
package operand_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchronizer, debouncer and rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int               CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_count;

    // The level flips on the edge the count would reach DEBOUNCE_CYCLES,
    // so the press pulse is registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == LAST) begin
                r_count <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_count <= r_count + ONE;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - collects operand A, operand B and carry-in on successive button presses
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       btn,
    output logic [7:0] userInput,
    output logic       cin,
    output logic       valid,
    output logic [1:0] state
);

    logic       w_press;
    state_t     r_state;
    logic [7:0] r_user_input;
    logic       r_cin;
    logic       r_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .press(w_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT_A;
            r_user_input <= 8'h00;
            r_cin        <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                WAIT_A: if (w_press) begin
                    r_user_input[7:4] <= sw;
                    r_state           <= WAIT_B;
                end
                WAIT_B: if (w_press) begin
                    r_user_input[3:0] <= sw;
                    r_cin             <= cin_sw;
                    r_valid           <= 1'b1;
                    r_state           <= READY;
                end
                READY: if (w_press) begin
                    r_valid <= 1'b0;
                    r_state <= WAIT_A;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= WAIT_A;
                end
            endcase
        end
    end

    assign userInput = r_user_input;
    assign cin       = r_cin;
    assign valid     = r_valid;
    assign state     = r_state;

endmodule
